// File: rtl/mul_div_unit_if.sv
// Handshake/bus bundle for the iterative multiply/divide unit.
// master = issuing pipeline stage, slave = mul_div_unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULT/DIV unit with HI/LO result registers.
// Define MDU_SIGNED_EN to make op 10/11 two's-complement MULT/DIV.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  mul_div_unit_if.slave mdu
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] bv_q;
  logic             div_q;
  logic             bz_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dtry;
  logic [WIDTH:0]   ddiff;
  logic             dge;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MDU_SIGNED_EN
  logic             qneg_q, rneg_q;
  logic [WIDTH-1:0] araw_q;
  logic             a_neg, b_neg;
  logic [2*WIDTH-1:0] prod;
`else
  logic unused_op;
  assign unused_op = mdu.op[1];
`endif

  // Shared datapath: MUL keeps {acc,sh} as the product shifting right,
  // DIV keeps acc as partial remainder and shifts quotient bits into sh.
  always_comb begin
    msum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, bv_q} : '0);
    dtry  = {acc_q, sh_q[WIDTH-1]};
    dge   = dtry >= {1'b0, bv_q};
    ddiff = dtry - {1'b0, bv_q};
    if (div_q) begin
      acc_d = dge ? ddiff[WIDTH-1:0] : dtry[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], dge};
    end else begin
      acc_d = msum[WIDTH:1];
      sh_d  = {msum[0], sh_q[WIDTH-1:1]};
    end
  end

`ifdef MDU_SIGNED_EN
  always_comb begin
    a_neg = mdu.op[1] & mdu.a[WIDTH-1];
    b_neg = mdu.op[1] & mdu.b[WIDTH-1];
    a_mag = a_neg ? -mdu.a : mdu.a;
    b_mag = b_neg ? -mdu.b : mdu.b;
  end

  always_comb begin
    prod = {acc_d, sh_d};
    if (div_q) begin
      res_hi = rneg_q ? -acc_d : acc_d;
      res_lo = qneg_q ? -sh_d : sh_d;
    end else begin
      if (qneg_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
    if (div_q && bz_q) begin
      res_hi = araw_q;
      res_lo = '1;
    end
  end
`else
  // Restoring divide by zero naturally yields q=all ones, r=dividend.
  always_comb begin
    a_mag  = mdu.a;
    b_mag  = mdu.b;
    res_hi = acc_d;
    res_lo = sh_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      bv_q    <= '0;
      div_q   <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      araw_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mdu.start && !mdu.flush) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= a_mag;
            bv_q    <= b_mag;
            div_q   <= mdu.op[0];
            bz_q    <= (mdu.b == '0);
`ifdef MDU_SIGNED_EN
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            araw_q  <= mdu.a;
`endif
          end
        end
        RUN: begin
          if (mdu.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              dz_q    <= div_q & bz_q;
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              cnt_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdu.busy        = busy_q;
  assign mdu.done        = done_q;
  assign mdu.div_by_zero = dz_q;
  assign mdu.hi          = hi_q;
  assign mdu.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
// Signed vectors run only when MDU_SIGNED_EN is defined.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) m ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (m)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    m.start = 1'b1;
    m.op    = o;
    m.a     = x;
    m.b     = y;
    tick();
    m.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!m.done && lat < 200) begin
      if (m.busy) bc++;
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz);
    int lat, bc;
    issue(o, x, y);
    wait_done(lat, bc);
    chk({tag, "_lat"}, 64'(lat), 64'd32);
    chk({tag, "_hi"}, 64'(m.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(m.lo), 64'(elo));
    chk({tag, "_dz"}, 64'(m.div_by_zero), 64'(edz));
  endtask

  initial begin
    int lat, bc;
    m.start = 1'b0;
    m.op    = 2'b00;
    m.a     = '0;
    m.b     = '0;
    m.flush = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_done", 64'(m.done), 64'd0);
    chk("rst_hilo", {m.hi, m.lo}, 64'd0);
    rst = 1'b0;
    tick();

    // MULTU max*max with busy window
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc);
    chk("mul_max_lat", 64'(lat), 64'd32);
    chk("mul_max_busy", 64'(bc), 64'd32);
    chk("mul_max_bdone", 64'(m.busy), 64'd0);
    chk("mul_max", {m.hi, m.lo}, 64'hFFFFFFFE_00000001);
    tick();
    chk("done_pulse", 64'(m.done), 64'd0);

    run("divu", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run("divu0", 2'b01, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF, 1'b1);
    tick();
    chk("dz_clear", 64'(m.div_by_zero), 64'd0);

    // Flush mid-run keeps previous result
    run("mul34", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    issue(2'b01, 32'd9, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    chk("fl_busy_pre", 64'(m.busy), 64'd1);
    m.flush = 1'b1;
    tick();
    m.flush = 1'b0;
    chk("fl_busy", 64'(m.busy), 64'd0);
    chk("fl_done", 64'(m.done), 64'd0);
    chk("fl_hilo", {m.hi, m.lo}, 64'd12);
    run("fl_next", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // flush beats start in IDLE
    m.start = 1'b1;
    m.flush = 1'b1;
    tick();
    m.start = 1'b0;
    m.flush = 1'b0;
    chk("fl_start", 64'(m.busy), 64'd0);
    tick();
    chk("fl_start2", 64'(m.busy), 64'd0);

    // start held high through RUN, then back-to-back in done cycle
    m.start = 1'b1;
    m.op    = 2'b00;
    m.a     = 32'd5;
    m.b     = 32'd6;
    tick();
    wait_done(lat, bc);
    chk("hold_lat", 64'(lat), 64'd32);
    chk("hold_lo", 64'(m.lo), 64'd30);
    m.a = 32'd7;
    m.b = 32'd8;
    tick();
    m.start = 1'b0;
    chk("b2b_busy", 64'(m.busy), 64'd1);
    chk("b2b_done", 64'(m.done), 64'd0);
    wait_done(lat, bc);
    chk("b2b_lat", 64'(lat), 64'd32);
    chk("b2b_lo", 64'(m.lo), 64'd56);

    // reset mid-run
    issue(2'b00, 32'd9, 32'd9);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    chk("mrst_busy", 64'(m.busy), 64'd0);
    chk("mrst_flags", {62'd0, m.done, m.div_by_zero}, 64'd0);
    chk("mrst_hilo", {m.hi, m.lo}, 64'd0);
    rst = 1'b0;
    tick();

`ifdef MDU_SIGNED_EN
    run("mult_s", 2'b10, 32'hFFFFFFFD, 32'd5,
        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run("div_s", 2'b11, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_min", 2'b11, 32'h80000000, 32'hFFFFFFFF,
        32'd0, 32'h80000000, 1'b0);
    run("div_s0", 2'b11, 32'hFFFFFFFB, 32'd0,
        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
`else
    run("mult_u", 2'b10, 32'hFFFFFFFD, 32'd5,
        32'h00000004, 32'hFFFFFFF1, 1'b0);
    run("div_u", 2'b11, 32'hFFFFFFF9, 32'd2,
        32'd1, 32'h7FFFFFFC, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
